// File: rtl/gold_ring_noc.sv
// Four-node bidirectional ring NoC: per-node CW-in, CCW-in and PE-in single-entry
// buffers, hop-count routing, registered PE-out with ready/valid handshake.
module gold_ring_noc (
  input  logic        clk,
  input  logic        reset,
  input  logic        node0_pesi,
  input  logic [63:0] node0_pedi,
  output logic        node0_peri,
  output logic        node0_peso,
  output logic [63:0] node0_pedo,
  input  logic        node0_pero,
  output logic        node0_polarity,
  input  logic        node1_pesi,
  input  logic [63:0] node1_pedi,
  output logic        node1_peri,
  output logic        node1_peso,
  output logic [63:0] node1_pedo,
  input  logic        node1_pero,
  output logic        node1_polarity,
  input  logic        node2_pesi,
  input  logic [63:0] node2_pedi,
  output logic        node2_peri,
  output logic        node2_peso,
  output logic [63:0] node2_pedo,
  input  logic        node2_pero,
  output logic        node2_polarity,
  input  logic        node3_pesi,
  input  logic [63:0] node3_pedi,
  output logic        node3_peri,
  output logic        node3_peso,
  output logic [63:0] node3_pedo,
  input  logic        node3_pero,
  output logic        node3_polarity
);

  localparam int unsigned N = 4;
  localparam int unsigned W = 64;

  logic [N-1:0] pesi, pero, peri;
  logic [W-1:0] pedi [N];

  logic [N-1:0] cw_v, ccw_v, pe_v, po_v;
  logic [W-1:0] cw_d [N];
  logic [W-1:0] ccw_d [N];
  logic [W-1:0] pe_d [N];
  logic [W-1:0] po_d [N];
  logic         pol;

  logic [N-1:0] cw_ej, cw_fw, ccw_ej, ccw_fw, pe_ej, pe_wcw, pe_wccw, po_ok;
  logic [N-1:0] cw_ej_go, ccw_ej_go, pe_ej_go, cw_leave, ccw_leave;
  logic [N-1:0] cw_fw_go, ccw_fw_go, cw_free, ccw_free, pe_cw_go, pe_ccw_go, pe_leave;

  function automatic logic hop_zero(input logic [W-1:0] p);
    return p[55:48] == 8'd0;
  endfunction

  function automatic logic [W-1:0] dec_hop(input logic [W-1:0] p);
    logic [W-1:0] r;
    r = p;
    r[55:48] = p[55:48] - 8'd1;
    return r;
  endfunction

  assign pesi = {node3_pesi, node2_pesi, node1_pesi, node0_pesi};
  assign pero = {node3_pero, node2_pero, node1_pero, node0_pero};
  assign pedi[0] = node0_pedi;
  assign pedi[1] = node1_pedi;
  assign pedi[2] = node2_pedi;
  assign pedi[3] = node3_pedi;

  // Routing and arbitration; link readiness resolved by walking each ring
  // direction so that a fully occupied ring can rotate without a comb loop.
  always_comb begin : p_route
    logic [1:0] m;
    logic       res;
    m = '0;
    res = 1'b0;
    cw_ej = '0; cw_fw = '0; ccw_ej = '0; ccw_fw = '0;
    pe_ej = '0; pe_wcw = '0; pe_wccw = '0; po_ok = '0;
    cw_ej_go = '0; ccw_ej_go = '0; pe_ej_go = '0;
    cw_leave = '0; ccw_leave = '0; cw_fw_go = '0; ccw_fw_go = '0;
    cw_free = '0; ccw_free = '0; pe_cw_go = '0; pe_ccw_go = '0;
    pe_leave = '0; peri = '0;
    for (int i = 0; i < int'(N); i++) begin
      cw_ej[i]   = cw_v[i] && hop_zero(cw_d[i]);
      cw_fw[i]   = cw_v[i] && !hop_zero(cw_d[i]);
      ccw_ej[i]  = ccw_v[i] && hop_zero(ccw_d[i]);
      ccw_fw[i]  = ccw_v[i] && !hop_zero(ccw_d[i]);
      pe_ej[i]   = pe_v[i] && hop_zero(pe_d[i]);
      pe_wcw[i]  = pe_v[i] && !hop_zero(pe_d[i]) && !pe_d[i][62];
      pe_wccw[i] = pe_v[i] && !hop_zero(pe_d[i]) && pe_d[i][62];
      po_ok[i]   = !po_v[i] || pero[i];
      cw_ej_go[i]  = cw_ej[i] && po_ok[i];
      ccw_ej_go[i] = ccw_ej[i] && po_ok[i] && !cw_ej[i];
      pe_ej_go[i]  = pe_ej[i] && po_ok[i] && !cw_ej[i] && !ccw_ej[i];
    end
    for (int j = 0; j < int'(N); j++) begin
      res = 1'b1;
      for (int k = int'(N) - 1; k >= 0; k--) begin
        m = 2'(j + k);
        res = cw_fw[m] ? (!cw_v[2'(m + 2'd1)] || res) : cw_ej_go[m];
      end
      cw_leave[j] = res;
      res = 1'b1;
      for (int k = int'(N) - 1; k >= 0; k--) begin
        m = 2'(j - k);
        res = ccw_fw[m] ? (!ccw_v[2'(m - 2'd1)] || res) : ccw_ej_go[m];
      end
      ccw_leave[j] = res;
    end
    for (int i = 0; i < int'(N); i++) begin
      cw_fw_go[i]  = cw_fw[i] && cw_leave[i];
      ccw_fw_go[i] = ccw_fw[i] && ccw_leave[i];
      cw_free[i]   = !cw_v[i] || cw_leave[i];
      ccw_free[i]  = !ccw_v[i] || ccw_leave[i];
    end
    for (int i = 0; i < int'(N); i++) begin
      pe_cw_go[i]  = pe_wcw[i] && !cw_fw[i] && cw_free[2'(i + 1)];
      pe_ccw_go[i] = pe_wccw[i] && !ccw_fw[i] && ccw_free[2'(i - 1)];
      pe_leave[i]  = pe_ej_go[i] || pe_cw_go[i] || pe_ccw_go[i];
      peri[i]      = !pe_v[i] || pe_leave[i];
    end
  end

  // Buffer, PE-out and polarity state update.
  always_ff @(posedge clk) begin
    if (reset) begin
      cw_v  <= '0;
      ccw_v <= '0;
      pe_v  <= '0;
      po_v  <= '0;
      pol   <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        cw_d[i]  <= '0;
        ccw_d[i] <= '0;
        pe_d[i]  <= '0;
        po_d[i]  <= '0;
      end
    end else begin
      pol <= ~pol;
      for (int i = 0; i < int'(N); i++) begin
        if (cw_fw_go[2'(i - 1)]) begin
          cw_v[i] <= 1'b1;
          cw_d[i] <= dec_hop(cw_d[2'(i - 1)]);
        end else if (pe_cw_go[2'(i - 1)]) begin
          cw_v[i] <= 1'b1;
          cw_d[i] <= dec_hop(pe_d[2'(i - 1)]);
        end else if (cw_leave[i]) begin
          cw_v[i] <= 1'b0;
        end
        if (ccw_fw_go[2'(i + 1)]) begin
          ccw_v[i] <= 1'b1;
          ccw_d[i] <= dec_hop(ccw_d[2'(i + 1)]);
        end else if (pe_ccw_go[2'(i + 1)]) begin
          ccw_v[i] <= 1'b1;
          ccw_d[i] <= dec_hop(pe_d[2'(i + 1)]);
        end else if (ccw_leave[i]) begin
          ccw_v[i] <= 1'b0;
        end
        if (pesi[i] && peri[i]) begin
          pe_v[i] <= 1'b1;
          pe_d[i] <= pedi[i];
        end else if (pe_leave[i]) begin
          pe_v[i] <= 1'b0;
        end
        if (cw_ej_go[i]) begin
          po_v[i] <= 1'b1;
          po_d[i] <= cw_d[i];
        end else if (ccw_ej_go[i]) begin
          po_v[i] <= 1'b1;
          po_d[i] <= ccw_d[i];
        end else if (pe_ej_go[i]) begin
          po_v[i] <= 1'b1;
          po_d[i] <= pe_d[i];
        end else if (pero[i]) begin
          po_v[i] <= 1'b0;
        end
      end
    end
  end

  assign node0_peri = peri[0];
  assign node1_peri = peri[1];
  assign node2_peri = peri[2];
  assign node3_peri = peri[3];
  assign node0_peso = po_v[0];
  assign node1_peso = po_v[1];
  assign node2_peso = po_v[2];
  assign node3_peso = po_v[3];
  assign node0_pedo = po_d[0];
  assign node1_pedo = po_d[1];
  assign node2_pedo = po_d[2];
  assign node3_pedo = po_d[3];
  assign node0_polarity = pol;
  assign node1_polarity = pol;
  assign node2_polarity = pol;
  assign node3_polarity = pol;

endmodule

// File: tb/tb_gold_ring_noc.sv
// Directed bench for gold_ring_noc: single-packet vector table plus gather,
// collision, backpressure and mid-traffic reset sequences.
module tb_gold_ring_noc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pesi, pero;
  logic [63:0] pedi [4];
  wire  [3:0]  peri, peso, pol;
  wire  [63:0] pedo [4];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    int          c;
    int          n;
    logic [63:0] d;
  } ev_t;
  ev_t log_q[$];

  typedef struct {
    int          src;
    logic [63:0] pkt;
    int          dst;
    int          lat;
    logic [63:0] exp_d;
  } vec_t;
  vec_t vt[7];

  gold_ring_noc dut (
    .clk(clk), .reset(reset),
    .node0_pesi(pesi[0]), .node0_pedi(pedi[0]), .node0_peri(peri[0]),
    .node0_peso(peso[0]), .node0_pedo(pedo[0]), .node0_pero(pero[0]), .node0_polarity(pol[0]),
    .node1_pesi(pesi[1]), .node1_pedi(pedi[1]), .node1_peri(peri[1]),
    .node1_peso(peso[1]), .node1_pedo(pedo[1]), .node1_pero(pero[1]), .node1_polarity(pol[1]),
    .node2_pesi(pesi[2]), .node2_pedi(pedi[2]), .node2_peri(peri[2]),
    .node2_peso(peso[2]), .node2_pedo(pedo[2]), .node2_pero(pero[2]), .node2_polarity(pol[2]),
    .node3_pesi(pesi[3]), .node3_pedi(pedi[3]), .node3_peri(peri[3]),
    .node3_peso(peso[3]), .node3_pedo(pedo[3]), .node3_pero(pero[3]), .node3_polarity(pol[3])
  );

  always #5 clk = ~clk;

  // Edge counter: a packet loaded at edge E is logged with c == E.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every consumed delivery mid-cycle.
  always @(negedge clk) begin
    for (int n = 0; n < 4; n++)
      if (peso[n] && pero[n]) log_q.push_back('{cyc, n, pedo[n]});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input logic vc, input logic dir, input logic [5:0] rsv,
                                     input logic [7:0] h, input logic [15:0] src,
                                     input logic [31:0] pay);
    return {vc, dir, rsv, h, src, pay};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int   e0;
    ev_t  ev;
    int   cnt0, oth, idx1, idx3;
    logic [15:0] mask;
    logic seen1, seen3, ok1, ok3;
    logic [31:0] got1 [$];
    logic [31:0] got3 [$];
    ev_t  exp_g [3];

    vt[0] = '{1, 64'h4001_0001_0000_0000, 0, 2, 64'h4000_0001_0000_0000};
    vt[1] = '{0, mk(0, 0, 6'h00, 8'd0, 16'h0000, 32'h0000_1234), 0, 1,
                 mk(0, 0, 6'h00, 8'd0, 16'h0000, 32'h0000_1234)};
    vt[2] = '{2, mk(0, 0, 6'h00, 8'd3, 16'h0002, 32'hA5A5_0001), 1, 4,
                 mk(0, 0, 6'h00, 8'd0, 16'h0002, 32'hA5A5_0001)};
    vt[3] = '{3, mk(0, 1, 6'h00, 8'd2, 16'h0003, 32'h0000_0001), 1, 3,
                 mk(0, 1, 6'h00, 8'd0, 16'h0003, 32'h0000_0001)};
    vt[4] = '{0, mk(0, 0, 6'h00, 8'd5, 16'h0000, 32'h0000_0001), 1, 6,
                 mk(0, 0, 6'h00, 8'd0, 16'h0000, 32'h0000_0001)};
    vt[5] = '{1, mk(1, 0, 6'h2A, 8'd1, 16'h0001, 32'hDEAD_BEEF), 2, 2,
                 mk(1, 0, 6'h2A, 8'd0, 16'h0001, 32'hDEAD_BEEF)};
    vt[6] = '{2, mk(0, 1, 6'h00, 8'd7, 16'h0002, 32'h0000_0003), 3, 8,
                 mk(0, 1, 6'h00, 8'd0, 16'h0002, 32'h0000_0003)};

    reset = 1'b1;
    pesi = '0;
    pero = 4'hF;
    for (int i = 0; i < 4; i++) pedi[i] = '0;
    repeat (3) step();
    chk("reset_peso", 64'(peso), 64'h0);
    chk("reset_peri", 64'(peri), 64'hF);
    chk("reset_polarity", 64'(pol), 64'h0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("polarity_toggle", 64'(pol), (k % 2 == 0) ? 64'hF : 64'h0);
    end

    // Uncontended single packets.
    for (int v = 0; v < 7; v++) begin
      log_q.delete();
      pesi[vt[v].src] = 1'b1;
      pedi[vt[v].src] = vt[v].pkt;
      step();
      e0 = cyc;
      pesi = '0;
      repeat (10) step();
      chk("vec_count", 64'(log_q.size()), 64'd1);
      ev = (log_q.size() > 0) ? log_q[0] : '{-1, -1, 64'h0};
      chk("vec_node", 64'(ev.n), 64'(vt[v].dst));
      chk("vec_latency", 64'(ev.c - e0), 64'(vt[v].lat));
      chk("vec_data", ev.d, vt[v].exp_d);
    end

    // Gather to node0 from three same-edge injections.
    log_q.delete();
    pesi = 4'b1110;
    pedi[1] = mk(0, 1, 6'h00, 8'd1, 16'h0001, 32'h0);
    pedi[2] = mk(0, 0, 6'h00, 8'd2, 16'h0002, 32'h0);
    pedi[3] = mk(0, 0, 6'h00, 8'd1, 16'h0003, 32'h0);
    step();
    pesi = '0;
    repeat (10) step();
    cnt0 = 0; oth = 0; mask = '0;
    foreach (log_q[i]) begin
      if (log_q[i].n == 0) begin
        cnt0++;
        mask = mask | (16'(1) << log_q[i].d[35:32]);
      end else oth++;
    end
    chk("gather0_count", 64'(cnt0), 64'd3);
    chk("gather0_sources", 64'(mask), 64'h000E);
    chk("gather0_other_nodes", 64'(oth), 64'd0);

    // Gather to node2: CW/CCW collision, then a later CW arrival.
    log_q.delete();
    pesi = 4'b1010;
    pedi[1] = mk(0, 0, 6'h00, 8'd1, 16'h0001, 32'h2);
    pedi[3] = mk(0, 1, 6'h00, 8'd1, 16'h0003, 32'h2);
    step();
    e0 = cyc;
    pesi = 4'b0001;
    pedi[0] = mk(0, 0, 6'h00, 8'd2, 16'h0000, 32'h2);
    step();
    pesi = '0;
    repeat (10) step();
    exp_g[0] = '{e0 + 2, 2, mk(0, 0, 6'h00, 8'd0, 16'h0001, 32'h2)};
    exp_g[1] = '{e0 + 3, 2, mk(0, 1, 6'h00, 8'd0, 16'h0003, 32'h2)};
    exp_g[2] = '{e0 + 4, 2, mk(0, 0, 6'h00, 8'd0, 16'h0000, 32'h2)};
    chk("gather2_count", 64'(log_q.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      ev = (log_q.size() > k) ? log_q[k] : '{-1, -1, 64'h0};
      chk("gather2_cycle", 64'(ev.c), 64'(exp_g[k].c));
      chk("gather2_node", 64'(ev.n), 64'(exp_g[k].n));
      chk("gather2_data", ev.d, exp_g[k].d);
    end

    // Backpressure: node0 not ready while nodes 1 and 3 send three each.
    log_q.delete();
    pero[0] = 1'b0;
    idx1 = 0; idx3 = 0; seen1 = 1'b0; seen3 = 1'b0;
    for (int it = 0; it < 60 && (idx1 < 3 || idx3 < 3); it++) begin
      if (it == 15) begin
        chk("bp_nothing_consumed", 64'(log_q.size()), 64'd0);
        chk("bp_node1_peri_dropped", 64'(seen1), 64'd1);
        chk("bp_node3_peri_dropped", 64'(seen3), 64'd1);
        pero[0] = 1'b1;
      end
      pesi[1] = (idx1 < 3);
      pedi[1] = mk(0, 1, 6'h00, 8'd1, 16'h0001, 32'(idx1));
      pesi[3] = (idx3 < 3);
      pedi[3] = mk(0, 0, 6'h00, 8'd1, 16'h0003, 32'(idx3));
      @(negedge clk);
      if (!peri[1]) seen1 = 1'b1;
      if (!peri[3]) seen3 = 1'b1;
      ok1 = pesi[1] && peri[1];
      ok3 = pesi[3] && peri[3];
      step();
      if (ok1) idx1++;
      if (ok3) idx3++;
    end
    pesi = '0;
    pero[0] = 1'b1;
    chk("bp_all_injected", 64'(idx1 + idx3), 64'd6);
    repeat (15) step();
    chk("bp_delivered", 64'(log_q.size()), 64'd6);
    foreach (log_q[i]) begin
      if (log_q[i].n == 0 && log_q[i].d[47:32] == 16'h0001) got1.push_back(log_q[i].d[31:0]);
      if (log_q[i].n == 0 && log_q[i].d[47:32] == 16'h0003) got3.push_back(log_q[i].d[31:0]);
    end
    for (int k = 0; k < 3; k++) begin
      chk("bp_src1_order", (got1.size() > k) ? 64'(got1[k]) : 64'hFFFF, 64'(k));
      chk("bp_src3_order", (got3.size() > k) ? 64'(got3[k]) : 64'hFFFF, 64'(k));
    end

    // Reset with packets circulating and one parked in node1 PE-out.
    pero[1] = 1'b0;
    pesi = 4'b0111;
    pedi[0] = mk(0, 0, 6'h00, 8'd40, 16'h0000, 32'h7);
    pedi[1] = mk(0, 0, 6'h00, 8'd0, 16'h0001, 32'h7);
    pedi[2] = mk(0, 1, 6'h00, 8'd40, 16'h0002, 32'h7);
    step();
    pesi = '0;
    repeat (4) step();
    chk("rst_mid_parked", 64'(peso[1]), 64'd1);
    reset = 1'b1;
    step();
    chk("rst_mid_peso", 64'(peso), 64'h0);
    chk("rst_mid_peri", 64'(peri), 64'hF);
    reset = 1'b0;
    pero = 4'hF;
    log_q.delete();
    repeat (50) step();
    chk("rst_mid_no_stale", 64'(log_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
